vai_mmio_initiator: RTL

//  Drives the MMIO request side of CCI-P (c0 mmioWrValid/mmioRdValid plus the MMIO header) and consumes
//  the c2 mmioRdValid read responses. It turns a simple command port into MMIO traffic for the manager/
//  sub-AFU register space, and returns read data matched by tid. Used as the host-side stimulus engine
//  in the VAI mux environment and for on-chip self-configuration of offsets and resets.

---
 rtl/vai_mmio_initiator.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/vai_mmio_initiator.sv
`default_nettype none
// ============================================================================
// Module      : vai_mmio_initiator
// Description : Command-port to CCI-P MMIO request engine. Turns a simple
//               command handshake into c0 MMIO write/read strobes with an
//               MMIO header, and matches c2 read responses by tid. A read
//               waits for its response for up to TIMEOUT_CYCLES cycles,
//               counted from the ISSUE cycle. If no response arrives, it
//               completes with all-ones data and the timeout flag set.
//
// Ports       : pClk                  - clock, rising edge
//               pck_cp2af_softReset_n - asynchronous active-low reset
//               cmd_*                 - command handshake and fields
//               mmio_*                - c0 MMIO request strobes, header, data
//               c2_*                  - c2 MMIO read response from responder
//               rsp_*                 - single-cycle read completion
//               stray_count           - saturating count of unmatched c2
//                                       responses
// Revision    : 1.0 - initial release
// ============================================================================
module vai_mmio_initiator #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TID_WIDTH      = 9
) (
    input  logic                 pClk,
    input  logic                 pck_cp2af_softReset_n,
    // command port
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_is_write,
    input  logic                 cmd_len64,
    input  logic [15:0]          cmd_addr,
    input  logic [63:0]          cmd_wdata,
    // c0 MMIO request
    output logic                 mmio_wr_valid,
    output logic                 mmio_rd_valid,
    output logic [15:0]          mmio_addr,
    output logic [1:0]           mmio_length,
    output logic [TID_WIDTH-1:0] mmio_tid,
    output logic [63:0]          mmio_data,
    // c2 MMIO read response
    input  logic                 c2_rd_valid,
    input  logic [TID_WIDTH-1:0] c2_tid,
    input  logic [63:0]          c2_data,
    // read completion
    output logic                 rsp_valid,
    output logic [63:0]          rsp_data,
    output logic                 rsp_timeout,
    output logic                 rsp_error,
    output logic [15:0]          stray_count
);

    localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]           r_state;
    logic                 r_is_write;
    logic [TID_WIDTH-1:0] r_tid_ctr;
    logic [c_TMR_W-1:0]   r_timer;

    logic                 r_cmd_ready;
    logic                 r_mmio_wr_valid;
    logic                 r_mmio_rd_valid;
    logic [15:0]          r_mmio_addr;
    logic [1:0]           r_mmio_length;
    logic [TID_WIDTH-1:0] r_mmio_tid;
    logic [63:0]          r_mmio_data;
    logic                 r_rsp_valid;
    logic [63:0]          r_rsp_data;
    logic                 r_rsp_timeout;
    logic                 r_rsp_error;
    logic [15:0]          r_stray_count;

    logic                 w_accept;
    logic                 w_misaligned;
    logic                 w_match;
    logic                 w_timer_expired;

    assign w_accept        = cmd_valid && r_cmd_ready;
    // A 64-bit access must start on an even dword.
    assign w_misaligned    = cmd_len64 && cmd_addr[0];
    // mmio_tid holds the tid of the outstanding read while waiting.
    assign w_match         = c2_rd_valid && (r_state == S_WAIT) && (c2_tid == r_mmio_tid);
    assign w_timer_expired = (r_timer >= c_TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            r_state         <= S_IDLE;
            r_is_write      <= 1'b0;
            r_tid_ctr       <= '0;
            r_timer         <= '0;
            r_cmd_ready     <= 1'b0;
            r_mmio_wr_valid <= 1'b0;
            r_mmio_rd_valid <= 1'b0;
            r_mmio_addr     <= '0;
            r_mmio_length   <= '0;
            r_mmio_tid      <= '0;
            r_mmio_data     <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_data      <= '0;
            r_rsp_timeout   <= 1'b0;
            r_rsp_error     <= 1'b0;
            r_stray_count   <= '0;
        end else begin
            // Strobes are single-cycle pulses.
            r_mmio_wr_valid <= 1'b0;
            r_mmio_rd_valid <= 1'b0;
            r_rsp_valid     <= 1'b0;

            // Any c2 response not matching the outstanding read is stray,
            // including every response that arrives outside WAIT.
            if (c2_rd_valid && !w_match && (r_stray_count != 16'hFFFF)) begin
                r_stray_count <= r_stray_count + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        if (w_misaligned) begin
                            // Rejected without any bus activity.
                            r_state       <= S_RESP;
                            r_rsp_valid   <= 1'b1;
                            r_rsp_data    <= '1;
                            r_rsp_timeout <= 1'b0;
                            r_rsp_error   <= 1'b1;
                        end else begin
                            r_state         <= S_ISSUE;
                            r_is_write      <= cmd_is_write;
                            r_mmio_wr_valid <= cmd_is_write;
                            r_mmio_rd_valid <= !cmd_is_write;
                            r_mmio_addr     <= cmd_addr;
                            r_mmio_length   <= {1'b0, cmd_len64};
                            r_mmio_data     <= cmd_wdata;
                            r_mmio_tid      <= cmd_is_write ? '0 : r_tid_ctr;
                            // The timer counts from the ISSUE cycle.
                            r_timer         <= '0;
                            if (!cmd_is_write) begin
                                r_tid_ctr <= r_tid_ctr + 1'b1;
                            end
                        end
                    end
                end

                S_ISSUE: begin
                    r_timer <= r_timer + 1'b1;
                    if (r_is_write) begin
                        r_state     <= S_IDLE;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // A match in the expiry cycle takes precedence.
                    if (w_match) begin
                        r_state       <= S_RESP;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_data    <= c2_data;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_error   <= 1'b0;
                    end else if (w_timer_expired) begin
                        r_state       <= S_RESP;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_data    <= '1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_error   <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                default: begin
                    // S_RESP: rsp_valid is high for this one cycle.
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign mmio_wr_valid = r_mmio_wr_valid;
    assign mmio_rd_valid = r_mmio_rd_valid;
    assign mmio_addr     = r_mmio_addr;
    assign mmio_length   = r_mmio_length;
    assign mmio_tid      = r_mmio_tid;
    assign mmio_data     = r_mmio_data;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = r_rsp_data;
    assign rsp_timeout   = r_rsp_timeout;
    assign rsp_error     = r_rsp_error;
    assign stray_count   = r_stray_count;

endmodule
`default_nettype wire
